// File: rtl/mem_arbiter.sv
`default_nettype none

`ifndef BUS_NONE
`define BUS_NONE  4'd0
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  4'd1
`endif
`ifndef BUS_STORE
`define BUS_STORE 4'd2
`endif

// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates the single unified memory port between the
//                instruction-fetch (IF) and data-memory (DM) pipeline stages.
//                One bus transaction is outstanding at a time. DM has
//                priority, but IF is forced to win after STARVE_MAX
//                consecutive DM grants taken while IF was waiting.
//  Ports       : clk, rst             - clock, async active-high reset
//                if_req/if_addr       - fetch request (held until if_done)
//                if_rdata/if_done     - fetch data + one-cycle done pulse
//                dm_cmd/dm_addr/
//                dm_wdata             - data request (held until dm_done)
//                dm_rdata/dm_done     - load data + one-cycle done pulse
//                mem_cmd/mem_addr/
//                mem_wdata            - bus command to memory
//                mem_accept           - memory took the command this cycle
//                mem_rvalid/mem_rdata - load response from memory
//                if_stall/dm_stall    - combinational stage stalls
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic [3:0]        dm_cmd,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic [3:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_accept,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_stall,
  output logic              dm_stall
);

  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);

  localparam logic [2:0] C_ST_IDLE    = 3'd0;
  localparam logic [2:0] C_ST_REQ_IF  = 3'd1;
  localparam logic [2:0] C_ST_WAIT_IF = 3'd2;
  localparam logic [2:0] C_ST_REQ_DM  = 3'd3;
  localparam logic [2:0] C_ST_WAIT_DM = 3'd4;
  localparam logic [2:0] C_ST_DONE    = 3'd5;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [3:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_owner_dm;
  logic              r_if_done;
  logic              r_dm_done;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  logic              w_dm_pend;
  logic              w_grant_dm;
  logic              w_grant_if;
  logic              w_capture;

  // Any command other than LOAD/STORE counts as no request.
  assign w_dm_pend = (dm_cmd == `BUS_LOAD) || (dm_cmd == `BUS_STORE);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_grant_dm  = 1'b0;
    w_grant_if  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      C_ST_IDLE: begin
        if (w_dm_pend && (!if_req || (r_starve_cnt < C_STARVE_MAX))) begin
          w_state_nxt = C_ST_REQ_DM;
          w_grant_dm  = 1'b1;
        end else if (if_req) begin
          w_state_nxt = C_ST_REQ_IF;
          w_grant_if  = 1'b1;
        end
      end
      C_ST_REQ_IF, C_ST_REQ_DM: begin
        // rvalid only counts here when the command is accepted the same cycle.
        if (mem_accept) begin
          if (r_cmd == `BUS_STORE) begin
            w_state_nxt = C_ST_DONE;
          end else if (mem_rvalid) begin
            w_state_nxt = C_ST_DONE;
            w_capture   = 1'b1;
          end else begin
            w_state_nxt = (r_state == C_ST_REQ_IF) ? C_ST_WAIT_IF : C_ST_WAIT_DM;
          end
        end
      end
      C_ST_WAIT_IF, C_ST_WAIT_DM: begin
        if (mem_rvalid) begin
          w_state_nxt = C_ST_DONE;
          w_capture   = 1'b1;
        end
      end
      C_ST_DONE: begin
        // Requesters update their requests on this edge; no grant this cycle.
        w_state_nxt = C_ST_IDLE;
      end
      default: begin
        w_state_nxt = C_ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers: latched command, starvation counter, done/rdata
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_cmd        <= `BUS_NONE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_owner_dm   <= 1'b0;
      r_if_done    <= 1'b0;
      r_dm_done    <= 1'b0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
    end else begin
      if (w_grant_dm) begin
        r_cmd      <= dm_cmd;
        r_addr     <= dm_addr;
        r_wdata    <= dm_wdata;
        r_owner_dm <= 1'b1;
        // Only DM wins that make a waiting IF wait longer are counted.
        if (if_req && (r_starve_cnt != C_STARVE_MAX)) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end else if (w_grant_if) begin
        r_cmd        <= `BUS_LOAD;
        r_addr       <= if_addr;
        r_owner_dm   <= 1'b0;
        r_starve_cnt <= '0;
      end

      if (w_capture) begin
        if (r_owner_dm) begin
          r_dm_rdata <= mem_rdata;
        end else begin
          r_if_rdata <= mem_rdata;
        end
      end

      // Done flags are high exactly for the cycle spent in DONE.
      r_if_done <= (w_state_nxt == C_ST_DONE) && !r_owner_dm;
      r_dm_done <= (w_state_nxt == C_ST_DONE) &&  r_owner_dm;
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    mem_cmd   = `BUS_NONE;
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    if ((r_state == C_ST_REQ_IF) || (r_state == C_ST_REQ_DM)) begin
      mem_cmd = r_cmd;
    end
  end

  assign if_done  = r_if_done;
  assign dm_done  = r_dm_done;
  assign if_rdata = r_if_rdata;
  assign dm_rdata = r_dm_rdata;
  assign if_stall = if_req & ~r_if_done;
  assign dm_stall = w_dm_pend & ~r_dm_done;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none

`ifndef BUS_NONE
`define BUS_NONE  4'd0
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  4'd1
`endif
`ifndef BUS_STORE
`define BUS_STORE 4'd2
`endif

// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter. The bench
//                plays both requesters and the memory, cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic [3:0]  dm_cmd;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic [3:0]  mem_cmd;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_accept;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        if_stall;
  logic        dm_stall;

  int total  = 0;
  int passed = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_done    (if_done),
    .dm_cmd     (dm_cmd),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_done    (dm_done),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_accept (mem_accept),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .if_stall   (if_stall),
    .dm_stall   (dm_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  logic [31:0] exp_grant [7];
  logic [31:0] granted;
  int          n_dm;

  initial begin
    exp_grant = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h300, 32'h410, 32'h414};

    // ---- reset with both requests applied ----
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h0; dm_cmd = `BUS_LOAD;
    dm_addr = 32'h0; dm_wdata = 32'h0;
    mem_accept = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    chk("rst_if_done",   {31'd0, if_done}, 32'd0);
    chk("rst_dm_done",   {31'd0, dm_done}, 32'd0);
    chk("rst_if_rdata",  if_rdata,         32'd0);
    chk("rst_dm_rdata",  dm_rdata,         32'd0);
    chk("rst_mem_cmd",   {28'd0, mem_cmd}, {28'd0, `BUS_NONE});
    chk("rst_mem_addr",  mem_addr,         32'd0);
    chk("rst_mem_wdata", mem_wdata,        32'd0);
    if_req = 1'b0; dm_cmd = `BUS_NONE;
    tick();
    rst = 1'b0;
    tick();
    chk("idle_mem_cmd", {28'd0, mem_cmd}, {28'd0, `BUS_NONE});

    // ---- IF only ----
    if_req = 1'b1; if_addr = 32'h100;
    #1 chk("if_c0_stall", {31'd0, if_stall}, 32'd1);
    tick();                                     // cycle 1: REQ_IF
    chk("if_c1_cmd",   {28'd0, mem_cmd}, {28'd0, `BUS_LOAD});
    chk("if_c1_addr",  mem_addr,         32'h100);
    chk("if_c1_stall", {31'd0, if_stall}, 32'd1);
    mem_accept = 1'b1;
    tick();                                     // cycle 2: WAIT_IF
    mem_accept = 1'b0;
    chk("if_c2_cmd",   {28'd0, mem_cmd}, {28'd0, `BUS_NONE});
    chk("if_c2_stall", {31'd0, if_stall}, 32'd1);
    chk("if_c2_done",  {31'd0, if_done},  32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h00A00093;
    tick();                                     // cycle 3: DONE
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("if_c3_done",  {31'd0, if_done},  32'd1);
    chk("if_c3_rdata", if_rdata,          32'h00A00093);
    chk("if_c3_stall", {31'd0, if_stall}, 32'd0);
    chk("if_c3_cmd",   {28'd0, mem_cmd},  {28'd0, `BUS_NONE});
    if_req = 1'b0;
    tick();
    chk("if_c4_done",  {31'd0, if_done},  32'd0);
    chk("if_c4_hold",  if_rdata,          32'h00A00093);

    // ---- simultaneous IF + DM store: DM first ----
    if_req = 1'b1; if_addr = 32'h104;
    dm_cmd = `BUS_STORE; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
    tick();                                     // REQ_DM
    chk("sim_cmd",   {28'd0, mem_cmd}, {28'd0, `BUS_STORE});
    chk("sim_addr",  mem_addr,         32'h200);
    chk("sim_wdata", mem_wdata,        32'hDEADBEEF);
    mem_accept = 1'b1;
    tick();                                     // DONE
    mem_accept = 1'b0;
    chk("sim_dm_done",  {31'd0, dm_done},  32'd1);
    chk("sim_if_done",  {31'd0, if_done},  32'd0);
    chk("sim_dm_stall", {31'd0, dm_stall}, 32'd0);
    chk("sim_if_stall", {31'd0, if_stall}, 32'd1);
    dm_cmd = `BUS_NONE;
    tick();                                     // IDLE
    chk("sim_gap_cmd",  {28'd0, mem_cmd},  {28'd0, `BUS_NONE});
    chk("sim_gap_done", {31'd0, dm_done},  32'd0);
    tick();                                     // REQ_IF
    chk("sim_if_cmd",  {28'd0, mem_cmd}, {28'd0, `BUS_LOAD});
    chk("sim_if_addr", mem_addr,         32'h104);
    mem_accept = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    tick();                                     // DONE
    mem_accept = 1'b0; mem_rvalid = 1'b0;
    chk("sim_if_done2", {31'd0, if_done}, 32'd1);
    chk("sim_if_rdata", if_rdata,         32'h11111111);
    if_req = 1'b0;
    tick();

    // ---- starvation: IF held, DM issues 6 back-to-back loads ----
    if_req = 1'b1; if_addr = 32'h300;
    dm_cmd = `BUS_LOAD; dm_addr = 32'h400; n_dm = 0;
    for (int g = 0; g < 7; g++) begin
      for (int w = 0; w < 10 && mem_cmd == `BUS_NONE; w++) tick();
      chk($sformatf("starve_grant_seen%0d", g), {31'd0, mem_cmd != `BUS_NONE}, 32'd1);
      granted = mem_addr;
      chk($sformatf("starve_grant%0d", g), granted, exp_grant[g]);
      mem_accept = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hA000_0000 + g;
      tick();                                   // DONE
      mem_accept = 1'b0; mem_rvalid = 1'b0;
      if (exp_grant[g] == 32'h300) begin
        chk($sformatf("starve_if_done%0d", g), {31'd0, if_done}, 32'd1);
        chk($sformatf("starve_if_rdata%0d", g), if_rdata, 32'hA000_0000 + g);
      end else begin
        chk($sformatf("starve_dm_done%0d", g), {31'd0, dm_done}, 32'd1);
        n_dm++;
        if (n_dm < 6) dm_addr = 32'h400 + 32'(4 * n_dm);
        else dm_cmd = `BUS_NONE;
      end
      if (g == 6) if_req = 1'b0;
    end
    tick();

    // ---- memory backpressure on a DM load; stray rvalid ignored ----
    dm_cmd = `BUS_LOAD; dm_addr = 32'h500;
    tick();                                     // REQ_DM
    mem_rvalid = 1'b1; mem_rdata = 32'hBADBAD00;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_cmd%0d", i),   {28'd0, mem_cmd},  {28'd0, `BUS_LOAD});
      chk($sformatf("bp_addr%0d", i),  mem_addr,          32'h500);
      chk($sformatf("bp_stall%0d", i), {31'd0, dm_stall}, 32'd1);
      chk($sformatf("bp_done%0d", i),  {31'd0, dm_done},  32'd0);
      tick();
    end
    mem_rvalid = 1'b0;
    chk("bp_rdata_kept", dm_rdata, 32'hA0000006);
    mem_accept = 1'b1;
    tick();                                     // WAIT_DM
    mem_accept = 1'b0;
    chk("bp_wait_cmd", {28'd0, mem_cmd}, {28'd0, `BUS_NONE});
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();                                     // DONE
    mem_rvalid = 1'b0;
    chk("bp_done",  {31'd0, dm_done}, 32'd1);
    chk("bp_rdata", dm_rdata,         32'hCAFEF00D);
    dm_cmd = `BUS_NONE;
    tick();

    // ---- same-cycle accept + rvalid skips WAIT_DM ----
    dm_cmd = `BUS_LOAD; dm_addr = 32'h600;
    tick();                                     // REQ_DM
    mem_accept = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    tick();                                     // DONE
    mem_accept = 1'b0; mem_rvalid = 1'b0;
    chk("fast_done",  {31'd0, dm_done}, 32'd1);
    chk("fast_rdata", dm_rdata,         32'h12345678);
    dm_cmd = `BUS_NONE;
    tick();
    chk("fast_after", {31'd0, dm_done}, 32'd0);

    // ---- reset in WAIT_DM, later rvalid ignored ----
    dm_cmd = `BUS_LOAD; dm_addr = 32'h700;
    tick();                                     // REQ_DM
    mem_accept = 1'b1;
    tick();                                     // WAIT_DM
    mem_accept = 1'b0;
    chk("rw_wait_done", {31'd0, dm_done}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rw_rst_cmd",   {28'd0, mem_cmd}, {28'd0, `BUS_NONE});
    chk("rw_rst_rdata", dm_rdata,         32'd0);
    chk("rw_rst_addr",  mem_addr,         32'd0);
    dm_cmd = `BUS_NONE;
    tick();
    rst = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    tick();
    mem_rvalid = 1'b0;
    chk("rw_late_done",  {31'd0, dm_done}, 32'd0);
    chk("rw_late_rdata", dm_rdata,         32'd0);
    tick();
    chk("rw_late_done2", {31'd0, dm_done}, 32'd0);
    chk("rw_late_cmd",   {28'd0, mem_cmd}, {28'd0, `BUS_NONE});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and the data-memory stage (DM) of the 5-stage pipeline.
- Sequences one outstanding bus transaction at a time through a small FSM.
- Returns read data and one-cycle done pulses to each requester.
- Produces per-requester stall signals that the pipeline enable logic ANDs into its stage enables.
- Data requests have priority, with a bounded-starvation guarantee for IF.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive DM wins while IF is pending before IF is forced to win once.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- if_req  in  1  IF fetch request; held stable until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction, valid while if_done=1.
- if_done  out  1  one-cycle completion pulse for IF.
- dm_cmd  in  4  DM command (`BUS_NONE/`BUS_LOAD/`BUS_STORE); held stable until dm_done.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data, valid while dm_done=1.
- dm_done  out  1  one-cycle completion pulse for DM.
- mem_cmd  out  4  bus command; `BUS_NONE when idle.
- mem_addr  out  ADDR_W  bus address.
- mem_wdata  out  DATA_W  bus store data.
- mem_accept  in  1  memory accepts the current command this cycle.
- mem_rvalid  in  1  load data valid this cycle.
- mem_rdata  in  DATA_W  load data from memory.
- if_stall  out  1  = if_req & ~if_done (combinational).
- dm_stall  out  1  = (dm_cmd is LOAD or STORE) & ~dm_done (combinational).

Behaviour:
- Reset (asynchronous, active-high, any state):
  - state=IDLE, starve_cnt=0.
  - Latched cmd=`BUS_NONE; latched addr/data=0.
  - if_done=dm_done=0, if_rdata=dm_rdata=0.
  - mem_cmd=`BUS_NONE, mem_addr=0, mem_wdata=0.
  - A memory response arriving after reset while in IDLE is ignored.
- dm_cmd values other than LOAD/STORE are treated as `BUS_NONE.
- States: IDLE, REQ_IF, WAIT_IF, REQ_DM, WAIT_DM, DONE. The done flags and rdata are registers.
- IDLE grant rule:
  - DM pending and (IF not pending or starve_cnt<STARVE_MAX): go to REQ_DM, latch dm_cmd/dm_addr/dm_wdata. If IF is also pending, starve_cnt++ (saturates at STARVE_MAX).
  - Else if IF pending: go to REQ_IF, latch `BUS_LOAD/if_addr, starve_cnt=0.
  - Else stay in IDLE.
- mem_cmd/mem_addr/mem_wdata:
  - Driven from the latched registers in REQ_IF/REQ_DM.
  - `BUS_NONE (addr/data held) in all other states.
- REQ_x, mem_accept=0: hold the command; no timeout.
- REQ_x, mem_accept=1:
  - Store: go to DONE.
  - Load: go to WAIT_x. If mem_rvalid=1 in the same cycle, capture mem_rdata and go directly to DONE.
- mem_rvalid is ignored in REQ_x unless mem_accept=1.
- WAIT_x, mem_rvalid=1: capture mem_rdata into x_rdata, go to DONE.
- DONE:
  - The owner's done flag is 1 for exactly this cycle.
  - No new grant is made in this cycle; the requester updates its request on the done edge.
  - Next state is IDLE.
- Minimum latency, request to done:
  - Store: 2 cycles (IDLE, REQ, DONE).
  - Load: 2 cycles with same-cycle accept+rvalid; 3 cycles otherwise.
- Back-to-back requests: the minimum gap between two grants is one IDLE cycle after DONE.
- x_rdata holds its value until the next capture.
- Starvation bound: IF waits at most STARVE_MAX DM transactions while continuously requesting.

Test Plan:
- Reset with if_req=1 and dm_cmd=`BUS_LOAD applied, then deasserted → all registered outputs 0 and mem_cmd=`BUS_NONE. Asserting rst during WAIT_DM → IDLE next edge, dm_done never pulses, and a later mem_rvalid is ignored.
- IF only: if_req=1, if_addr=0x100; memory accepts in cycle 1 and returns 0x00A00093 in cycle 2 → if_done=1 with if_rdata=0x00A00093 in cycle 3; if_stall=1 in cycles 0–2 and 0 in cycle 3; mem_cmd=`BUS_LOAD only in cycle 1.
- Simultaneous requests: if_req=1 and dm_cmd=`BUS_STORE at addr 0x200, data 0xDEADBEEF → DM granted first; mem_wdata=0xDEADBEEF; dm_done pulses, then IF is granted on the next IDLE.
- Starvation: if_req held at 1 and DM issues 6 back-to-back loads, STARVE_MAX=4 → grant order DM,DM,DM,DM,IF,DM,DM.
- Memory backpressure: mem_accept held at 0 for 5 cycles in REQ_DM → mem_cmd/mem_addr stable throughout, dm_stall=1, no done pulse; completion occurs after accept.
- Same-cycle accept+rvalid for a DM load of 0x12345678 → dm_done in the following cycle with dm_rdata=0x12345678; the WAIT_DM state is skipped.
